// File: rtl/sha_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : sha_pkg                                                |
// | Description : Shared types and constants for the SHA message         |
// |               schedule window (FSM states, window depth, sigma       |
// |               rotate/shift amounts for SHA-256 and SHA-512).         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package sha_pkg;

  // Schedule window control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } sched_state_e;

  // Number of words held by the sliding schedule window
  localparam int SCHED_DEPTH = 16;

  // SHA-256 small sigma amounts (32-bit words)
  localparam int SIG256_S0_ROT_A = 7;
  localparam int SIG256_S0_ROT_B = 18;
  localparam int SIG256_S0_SHR   = 3;
  localparam int SIG256_S1_ROT_A = 17;
  localparam int SIG256_S1_ROT_B = 19;
  localparam int SIG256_S1_SHR   = 10;

  // SHA-512 small sigma amounts (64-bit words)
  localparam int SIG512_S0_ROT_A = 1;
  localparam int SIG512_S0_ROT_B = 8;
  localparam int SIG512_S0_SHR   = 7;
  localparam int SIG512_S1_ROT_A = 19;
  localparam int SIG512_S1_ROT_B = 61;
  localparam int SIG512_S1_SHR   = 6;

endpackage
`default_nettype wire

// File: rtl/sha_small_sigma.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : sha_small_sigma                                        |
// | Description : Combinational SHA small sigma0/sigma1 of one word.     |
// |               WORD_W selects the SHA-256 (32) or SHA-512 (64) set.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sha_small_sigma
  import sha_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] s0,
  output logic [WORD_W-1:0] s1
);

  // Rotate right by a constant amount within one word
  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input int n);
    return (v >> n) | (v << (WORD_W - n));
  endfunction

  generate
    if (WORD_W == 32) begin : g_sha256
      assign s0 = rotr(x, SIG256_S0_ROT_A) ^ rotr(x, SIG256_S0_ROT_B) ^ (x >> SIG256_S0_SHR);
      assign s1 = rotr(x, SIG256_S1_ROT_A) ^ rotr(x, SIG256_S1_ROT_B) ^ (x >> SIG256_S1_SHR);
    end else if (WORD_W == 64) begin : g_sha512
      assign s0 = rotr(x, SIG512_S0_ROT_A) ^ rotr(x, SIG512_S0_ROT_B) ^ (x >> SIG512_S0_SHR);
      assign s1 = rotr(x, SIG512_S1_ROT_A) ^ rotr(x, SIG512_S1_ROT_B) ^ (x >> SIG512_S1_SHR);
    end else begin : g_bad_word_w
      $error("sha_small_sigma: WORD_W must be 32 or 64");
      assign s0 = '0;
      assign s1 = '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/sha_msg_sched_window.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : sha_msg_sched_window                                   |
// | Description : 16-word sliding message-schedule window. Loads one     |
// |               block over valid/ready, then streams W_0..W_(ROUNDS-1) |
// |               expanding W_16 onward in place.                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sha_msg_sched_window
  import sha_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  parameter int IDX_W  = $clog2(ROUNDS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_data,
  output logic [IDX_W-1:0]  w_index,
  output logic              busy,
  output logic              done
);

  generate
    if (ROUNDS < SCHED_DEPTH) begin : g_bad_rounds
      $error("sha_msg_sched_window: ROUNDS must be >= 16");
    end
  endgenerate

  sched_state_e      state_q;
  logic [3:0]        load_cnt_q;
  logic [IDX_W-1:0]  t_q;
  logic              in_ready_q;
  logic              w_valid_q;
  logic              busy_q;
  logic              done_q;

  logic [WORD_W-1:0] win_q [SCHED_DEPTH];
  logic [WORD_W-1:0] win_d [SCHED_DEPTH];

  logic [WORD_W-1:0] sig0_w1;
  logic [WORD_W-1:0] sig1_w1_unused;
  logic [WORD_W-1:0] sig0_w14_unused;
  logic [WORD_W-1:0] sig1_w14;
  logic [WORD_W-1:0] expand_word;
  logic              load_acc;
  logic              run_acc;

  // Handshakes qualified by the registered ready/valid; clear cancels both
  assign load_acc = in_ready_q & in_valid & ~clear;
  assign run_acc  = w_valid_q & w_ready & ~clear;

  sha_small_sigma #(.WORD_W(WORD_W)) u_sigma_w1 (
    .x  (win_q[1]),
    .s0 (sig0_w1),
    .s1 (sig1_w1_unused)
  );

  sha_small_sigma #(.WORD_W(WORD_W)) u_sigma_w14 (
    .x  (win_q[14]),
    .s0 (sig0_w14_unused),
    .s1 (sig1_w14)
  );

  // W_(t+16) = s1(W_(t+14)) + W_(t+9) + s0(W_(t+1)) + W_t, modulo word size
  assign expand_word = sig1_w14 + win_q[9] + sig0_w1 + win_q[0];

  // Next window: shift down one place on any accepted word, else hold
  always_comb begin
    for (int i = 0; i < SCHED_DEPTH; i++) begin
      win_d[i] = win_q[i];
    end
    if (load_acc || run_acc) begin
      for (int i = 0; i < SCHED_DEPTH - 1; i++) begin
        win_d[i] = win_q[i + 1];
      end
      win_d[SCHED_DEPTH-1] = load_acc ? in_data : expand_word;
    end
  end

  // Window storage
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SCHED_DEPTH; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SCHED_DEPTH; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  // Control FSM with registered handshake/status outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      load_cnt_q <= 4'd0;
      t_q        <= '0;
      in_ready_q <= 1'b0;
      w_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (clear) begin
      state_q    <= ST_IDLE;
      load_cnt_q <= 4'd0;
      t_q        <= '0;
      in_ready_q <= 1'b0;
      w_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= 4'd0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_acc) begin
            load_cnt_q <= load_cnt_q + 4'd1;
            if (load_cnt_q == 4'd15) begin
              state_q    <= ST_RUN;
              t_q        <= '0;
              in_ready_q <= 1'b0;
              w_valid_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (run_acc) begin
            if (t_q == IDX_W'(ROUNDS - 1)) begin
              state_q   <= ST_DONE;
              w_valid_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              t_q <= t_q + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          t_q     <= '0;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          w_valid_q  <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign w_valid  = w_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign w_data   = win_q[0];
  assign w_index  = t_q;

endmodule
`default_nettype wire

// File: tb/tb_sha_msg_sched_window.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : tb_sha_msg_sched_window                                |
// | Description : Scoreboard bench: SHA-256 and SHA-512 instances, with  |
// |               directed blocks, backpressure, clear and async reset.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_sha_msg_sched_window;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SHA-256 instance
  logic        start_a = 0, clear_a = 0, in_valid_a = 0, w_ready_a = 0;
  logic [31:0] in_data_a = '0;
  logic        in_ready_a, w_valid_a, busy_a, done_a;
  logic [31:0] w_data_a;
  logic [5:0]  w_index_a;

  sha_msg_sched_window #(.WORD_W(32), .ROUNDS(64)) dut_a (
    .CLK(clk), .RST(rst), .start(start_a), .clear(clear_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .w_valid(w_valid_a), .w_ready(w_ready_a), .w_data(w_data_a),
    .w_index(w_index_a), .busy(busy_a), .done(done_a)
  );

  // SHA-512 instance
  logic        start_b = 0, clear_b = 0, in_valid_b = 0, w_ready_b = 0;
  logic [63:0] in_data_b = '0;
  logic        in_ready_b, w_valid_b, busy_b, done_b;
  logic [63:0] w_data_b;
  logic [6:0]  w_index_b;

  sha_msg_sched_window #(.WORD_W(64), .ROUNDS(80)) dut_b (
    .CLK(clk), .RST(rst), .start(start_b), .clear(clear_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .w_valid(w_valid_b), .w_ready(w_ready_b), .w_data(w_data_b),
    .w_index(w_index_b), .busy(busy_b), .done(done_b)
  );

  // Golden model: textbook small sigmas and the W[t] recurrence
  function automatic logic [31:0] r32(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction
  function automatic logic [31:0] g0_32(input logic [31:0] v);
    return r32(v, 7) ^ r32(v, 18) ^ (v >> 3);
  endfunction
  function automatic logic [31:0] g1_32(input logic [31:0] v);
    return r32(v, 17) ^ r32(v, 19) ^ (v >> 10);
  endfunction
  function automatic logic [63:0] r64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction
  function automatic logic [63:0] g0_64(input logic [63:0] v);
    return r64(v, 1) ^ r64(v, 8) ^ (v >> 7);
  endfunction
  function automatic logic [63:0] g1_64(input logic [63:0] v);
    return r64(v, 19) ^ r64(v, 61) ^ (v >> 6);
  endfunction

  typedef struct { int idx; logic [63:0] data; } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  logic [31:0] blk_a [16];
  logic [31:0] sch_a [64];
  logic [63:0] blk_b [16];
  logic [63:0] sch_b [80];

  // Expected stream for A; abc block pins hand-computed words at t=0,15,16,17
  task automatic push_a(input bit hand);
    exp_t e;
    for (int t = 0; t < 16; t++) sch_a[t] = blk_a[t];
    for (int t = 16; t < 64; t++)
      sch_a[t] = g1_32(sch_a[t-2]) + sch_a[t-7] + g0_32(sch_a[t-15]) + sch_a[t-16];
    for (int t = 0; t < 64; t++) begin
      e.idx = t;
      e.data = {32'd0, sch_a[t]};
      if (hand && t == 0)  e.data = 64'h61626380;
      if (hand && t == 15) e.data = 64'h00000018;
      if (hand && t == 16) e.data = 64'h61626380;
      if (hand && t == 17) e.data = 64'h000F0000;
      q_a.push_back(e);
    end
  endtask

  task automatic push_b();
    exp_t e;
    for (int t = 0; t < 16; t++) sch_b[t] = blk_b[t];
    for (int t = 16; t < 80; t++)
      sch_b[t] = g1_64(sch_b[t-2]) + sch_b[t-7] + g0_64(sch_b[t-15]) + sch_b[t-16];
    for (int t = 0; t < 80; t++) begin
      e.idx = t;
      e.data = sch_b[t];
      if (t == 16) e.data = 64'h6162638000000000;
      if (t == 17) e.data = 64'h00030000000000C0;
      q_b.push_back(e);
    end
  endtask

  // Monitors: pop and compare on every accepted word; time each done pulse
  int done_a_cnt = 0, last_acc_a = -10;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (w_valid_a && w_ready_a && !clear_a) begin
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_extra_word: actual index=%0d required none", w_index_a);
        end else begin
          e = q_a.pop_front();
          chk("a_w_index", {58'd0, w_index_a}, e.idx);
          chk("a_w_data", {32'd0, w_data_a}, e.data);
          if (e.idx == 63) last_acc_a = cyc;
        end
      end
      if (done_a) begin
        done_a_cnt++;
        chk("a_done_timing", cyc, last_acc_a + 1);
      end
    end
  end

  int done_b_cnt = 0, last_acc_b = -10;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (w_valid_b && w_ready_b && !clear_b) begin
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_extra_word: actual index=%0d required none", w_index_b);
        end else begin
          e = q_b.pop_front();
          chk("b_w_index", {57'd0, w_index_b}, e.idx);
          chk("b_w_data", w_data_b, e.data);
          if (e.idx == 79) last_acc_b = cyc;
        end
      end
      if (done_b) begin
        done_b_cnt++;
        chk("b_done_timing", cyc, last_acc_b + 1);
      end
    end
  end

  // Offer n words of blk_a, optionally idling in_valid between words
  task automatic load_a(input int n, input bit gap);
    bit ok;
    for (int i = 0; i < n; i++) begin
      in_valid_a = 1'b1;
      in_data_a  = blk_a[i];
      ok = 1'b0;
      for (int g = 0; g < 40 && !ok; g++) begin
        @(negedge clk);
        ok = in_ready_a;
        @(posedge clk);
        #1;
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL a_load_timeout: actual word=%0d required accepted", i);
      end
      in_valid_a = 1'b0;
      if (gap && i < n - 1) tick();
    end
  endtask

  task automatic load_b();
    bit ok;
    for (int i = 0; i < 16; i++) begin
      in_valid_b = 1'b1;
      in_data_b  = blk_b[i];
      ok = 1'b0;
      for (int g = 0; g < 40 && !ok; g++) begin
        @(negedge clk);
        ok = in_ready_b;
        @(posedge clk);
        #1;
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL b_load_timeout: actual word=%0d required accepted", i);
      end
    end
    in_valid_b = 1'b0;
  endtask

  task automatic start_a_pulse();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_idx_a(input int idx);
    bit hit = 1'b0;
    for (int g = 0; g < 200 && !hit; g++) begin
      @(negedge clk);
      hit = w_valid_a && (w_index_a == 6'(idx));
    end
    chk("a_reach_index", {63'd0, hit}, 64'd1);
  endtask

  task automatic wait_done_a(input int n);
    for (int g = 0; g < 300 && done_a_cnt < n; g++) @(negedge clk);
    repeat (4) tick();
    chk("a_done_count", done_a_cnt, n);
    chk("a_queue_drained", q_a.size(), 0);
    chk("a_busy_after_done", {63'd0, busy_a}, 64'd0);
  endtask

  task automatic set_abc_a();
    for (int i = 0; i < 16; i++) blk_a[i] = 32'd0;
    blk_a[0]  = 32'h61626380;
    blk_a[15] = 32'h00000018;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready_a}, 0);
    chk("rst_w_valid", {63'd0, w_valid_a}, 0);
    chk("rst_busy", {63'd0, busy_a}, 0);
    chk("rst_done", {63'd0, done_a}, 0);
    chk("rst_w_data", {32'd0, w_data_a}, 0);
    chk("rst_w_index", {58'd0, w_index_a}, 0);
    chk("rst_b_w_valid", {63'd0, w_valid_b}, 0);
    rst = 1'b0;
    tick();

    // in_valid in IDLE consumes nothing; clear beats start
    in_valid_a = 1'b1; in_data_a = 32'hDEADBEEF;
    repeat (2) tick();
    chk("idle_in_ready", {63'd0, in_ready_a}, 0);
    in_valid_a = 1'b0;
    start_a = 1'b1; clear_a = 1'b1;
    tick();
    start_a = 1'b0; clear_a = 1'b0;
    chk("clear_beats_start", {63'd0, busy_a}, 0);

    // SHA-256 abc block with a 5-cycle stall at t=20
    set_abc_a();
    push_a(1'b1);
    w_ready_a = 1'b1;
    start_a_pulse();
    chk("load_in_ready", {63'd0, in_ready_a}, 1);
    load_a(16, 1'b0);
    chk("run_after_load", {63'd0, w_valid_a}, 1);
    chk("no_ready_in_run", {63'd0, in_ready_a}, 0);
    wait_idx_a(19);
    tick();
    w_ready_a = 1'b0;
    held = w_data_a;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_index", {58'd0, w_index_a}, 20);
      chk("stall_data", {32'd0, w_data_a}, {32'd0, sch_a[20]});
      chk("stall_stable", {32'd0, w_data_a}, {32'd0, held});
    end
    tick();
    w_ready_a = 1'b1;
    wait_done_a(1);

    // Load with in_valid toggling every other cycle
    for (int i = 0; i < 16; i++) blk_a[i] = 32'h01020304 * (i + 1) ^ 32'hA5000000;
    push_a(1'b0);
    start_a_pulse();
    load_a(16, 1'b1);
    chk("gap_run_after_load", {63'd0, w_valid_a}, 1);
    wait_done_a(2);

    // Clear at t=30, then a fresh abc block
    set_abc_a();
    push_a(1'b1);
    start_a_pulse();
    load_a(16, 1'b0);
    wait_idx_a(29);
    tick();
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    q_a.delete();
    chk("clear_w_valid", {63'd0, w_valid_a}, 0);
    chk("clear_busy", {63'd0, busy_a}, 0);
    chk("clear_in_ready", {63'd0, in_ready_a}, 0);
    repeat (10) tick();
    chk("clear_no_done", done_a_cnt, 2);
    push_a(1'b1);
    start_a_pulse();
    load_a(16, 1'b0);
    wait_done_a(3);

    // Async reset after 7 words of a load
    start_a_pulse();
    load_a(7, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", {63'd0, in_ready_a}, 0);
    chk("arst_busy", {63'd0, busy_a}, 0);
    chk("arst_w_valid", {63'd0, w_valid_a}, 0);
    chk("arst_w_data", {32'd0, w_data_a}, 0);
    chk("arst_w_index", {58'd0, w_index_a}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    chk("arst_idle", {63'd0, in_ready_a | busy_a | w_valid_a}, 0);
    chk("arst_no_done", done_a_cnt, 3);

    // SHA-512 abc block, 80 rounds
    for (int i = 0; i < 16; i++) blk_b[i] = 64'd0;
    blk_b[0]  = 64'h6162638000000000;
    blk_b[15] = 64'h18;
    push_b();
    w_ready_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    load_b();
    chk("b_run_after_load", {63'd0, w_valid_b}, 1);
    for (int g = 0; g < 300 && done_b_cnt < 1; g++) @(negedge clk);
    repeat (4) tick();
    chk("b_done_count", done_b_cnt, 1);
    chk("b_queue_drained", q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
